mt_twist_temper: RTL and testbench

Generation stage of the MT19937 core, downstream of the seeding stage. It reads the shared 624-word state RAM and twists each word in place. Each freshly twisted word is tempered and presented as a 32-bit random number on a valid/ready output port. The stage is active while the top-level FSM holds `current_state == 2'b10`.

---
 rtl/mt_pkg.sv | 63 ++++++
 rtl/mt_temper.sv | 28 ++
 rtl/mt_twist_temper.sv | 139 +++++++++++++
 tb/tb_mt_twist_temper.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_pkg.sv
// ---------------------------------------------------------------------------
// mt_pkg
// Shared constants, state encodings and helper functions for the MT19937
// core. Used by the seeding and generation stages.
//   - MT19937 parameters (state length, middle offset, twist/temper masks,
//     seeding multiplier).
//   - Top-level FSM encodings seen on current_state.
//   - Generation-stage FSM states.
//   - Index helpers for the circular 624-entry state RAM and the twist step.
// ---------------------------------------------------------------------------
package mt_pkg;

    localparam int unsigned MT_N       = 624;
    localparam int unsigned MT_M       = 397;
    localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
    localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
    localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
    localparam logic [31:0] TEMPER_B   = 32'h9D2C_5680;
    localparam logic [31:0] TEMPER_C   = 32'hEFC6_0000;
    localparam logic [31:0] SEED_F     = 32'd1812433253;

    localparam logic [9:0] IDX_LAST = 10'(MT_N - 1);     // 623
    localparam logic [9:0] MID_WRAP = 10'(MT_N - MT_M);  // 227: idx+M wraps from here

    // Top-level FSM encodings driven on current_state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEED = 2'b01,
        ST_GEN  = 2'b10,
        ST_DONE = 2'b11
    } top_state_e;

    // Generation-stage FSM.
    typedef enum logic [2:0] {
        G_IDLE,
        G_PRIME,
        G_LOAD,
        G_RD1,
        G_RD2,
        G_CALC,
        G_OUT
    } gen_state_e;

    // idx+1 with wrap 623 -> 0.
    function automatic logic [9:0] idx_inc(input logic [9:0] i);
        return (i == IDX_LAST) ? 10'd0 : i + 10'd1;
    endfunction

    // (idx + M) mod N without a divider.
    function automatic logic [9:0] idx_mid(input logic [9:0] i);
        return (i >= MID_WRAP) ? i - MID_WRAP : i + 10'(MT_M);
    endfunction

    // One MT19937 twist step: new mt[i] from mt[i], mt[i+1], mt[i+M].
    function automatic logic [31:0] twist(input logic [31:0] cur,
                                          input logic [31:0] nxt,
                                          input logic [31:0] mid);
        logic [31:0] y;
        y = (cur & UPPER_MASK) | (nxt & LOWER_MASK);
        return mid ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'h0);
    endfunction

endpackage

// File: rtl/mt_temper.sv
// ---------------------------------------------------------------------------
// mt_temper
// Combinational MT19937 tempering of one 32-bit state word.
// Ports:
//   y_i  in  32  raw state word
//   y_o  out 32  tempered output word
// ---------------------------------------------------------------------------
module mt_temper
    import mt_pkg::*;
(
    input  logic [31:0] y_i,
    output logic [31:0] y_o
);

    logic [31:0] y1;
    logic [31:0] y2;
    logic [31:0] y3;

    // NOTE: combinational logic uses blocking assignments so each step sees
    // the previous one within the same evaluation.
    always_comb begin
        y1  = y_i ^ (y_i >> 11);
        y2  = y1 ^ ((y1 << 7) & TEMPER_B);
        y3  = y2 ^ ((y2 << 15) & TEMPER_C);
        y_o = y3 ^ (y3 >> 18);
    end

endmodule

// File: rtl/mt_twist_temper.sv
// ---------------------------------------------------------------------------
// mt_twist_temper
// Generation stage of the MT19937 core. Streams through the shared 624-word
// state RAM, twists each word in place and presents it (tempered, or raw)
// on a valid/ready port. Active while current_state == ST_GEN.
//
// Build option: define MT_TEMPER_EN to output temper(new); otherwise the raw
// twisted state word is output (state-RAM debug). Timing is identical.
//
// Ports:
//   clk            in   1   clock
//   rst            in   1   synchronous active-high reset
//   current_state  in   2   top FSM state (ST_GEN runs, ST_SEED clears idx)
//   rd_addr        out  10  state RAM read address (1-cycle read latency)
//   rd_data        in   32  state RAM read data
//   wr_addr        out  10  state RAM write address
//   wr_data        out  32  state RAM write data
//   wr_en          out  1   state RAM write strobe (one cycle, in CALC)
//   rand_out       out  32  random word, held until the next word
//   rand_valid     out  1   rand_out valid
//   rand_ready     in   1   consumer accepts rand_out
//   busy           out  1   FSM not idle
// ---------------------------------------------------------------------------
module mt_twist_temper
    import mt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  current_state,
    output logic [9:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [9:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic [31:0] rand_out,
    output logic        rand_valid,
    input  logic        rand_ready,
    output logic        busy
);

    gen_state_e  state_q;
    logic [9:0]  idx_q;
    logic [9:0]  rd_addr_q;
    logic [31:0] cur_q;       // mt[idx]
    logic [31:0] nxt_q;       // mt[idx+1]
    logic [31:0] rand_q;

    logic [9:0]  idx_d;       // idx+1 with wrap
    logic [31:0] new_word;    // twisted mt[idx]
    logic [31:0] rand_d;      // value loaded into rand_out in CALC

    assign idx_d = idx_inc(idx_q);

    // mid = mt[idx+M] arrives on rd_data during CALC and is consumed
    // directly, so it never needs its own register.
    assign new_word = twist(cur_q, nxt_q, rd_data);

`ifdef MT_TEMPER_EN
    mt_temper u_temper (
        .y_i (new_word),
        .y_o (rand_d)
    );
`else
    assign rand_d = new_word;
`endif

    // NOTE: rd_addr is registered, so each state loads the address the
    // following state needs; the RAM answers one cycle after that.
    // NOTE: sequential state uses non-blocking assignments; the mode
    // overrides at the bottom rely on the last assignment winning.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= G_IDLE;
            idx_q     <= '0;
            rd_addr_q <= '0;
            cur_q     <= '0;
            nxt_q     <= '0;
            rand_q    <= '0;
        end else begin
            case (state_q)
                G_IDLE: begin
                    if (current_state == ST_GEN) begin
                        state_q   <= G_PRIME;
                        rd_addr_q <= idx_q;
                    end
                end
                G_PRIME: begin
                    state_q <= G_LOAD;
                end
                G_LOAD: begin
                    cur_q     <= rd_data;
                    rd_addr_q <= idx_d;
                    state_q   <= G_RD1;
                end
                G_RD1: begin
                    rd_addr_q <= idx_mid(idx_q);
                    state_q   <= G_RD2;
                end
                G_RD2: begin
                    nxt_q   <= rd_data;
                    state_q <= G_CALC;
                end
                G_CALC: begin
                    // cur carries over from nxt, so only the next word and
                    // the middle word are read per step.
                    rand_q  <= rand_d;
                    cur_q   <= nxt_q;
                    idx_q   <= idx_d;
                    state_q <= G_OUT;
                end
                G_OUT: begin
                    if (rand_ready) begin
                        rd_addr_q <= idx_d;
                        state_q   <= G_RD1;
                    end
                end
                default: state_q <= G_IDLE;
            endcase

            // Leaving generate drops back to IDLE from any state; idx is
            // kept so re-entry resumes at the next unwritten word.
            if (current_state != ST_GEN) begin
                state_q <= G_IDLE;
            end
            if (current_state == ST_SEED) begin
                idx_q <= '0;
            end
        end
    end

    assign rd_addr    = rd_addr_q;
    assign wr_en      = (state_q == G_CALC);
    assign wr_addr    = wr_en ? idx_q : '0;
    assign wr_data    = wr_en ? new_word : '0;
    assign rand_out   = rand_q;
    assign rand_valid = (state_q == G_OUT);
    assign busy       = (state_q != G_IDLE);

endmodule

// File: tb/tb_mt_twist_temper.sv
// ---------------------------------------------------------------------------
// tb_mt_twist_temper
// Self-checking bench for mt_twist_temper. Holds a behavioural state RAM and
// a reference MT19937 (whole-array twist, then indexed read-out) that tracks
// every word the DUT should emit.
// ---------------------------------------------------------------------------
module tb_mt_twist_temper;

    logic        clk;
    logic        rst;
    logic [1:0]  current_state;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] rand_out;
    logic        rand_valid;
    logic        rand_ready;
    logic        busy;

    mt_twist_temper dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (current_state),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .rand_out      (rand_out),
        .rand_valid    (rand_valid),
        .rand_ready    (rand_ready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mdl_mt [624];
    int          mdl_pos;
    int          mdl_cnt;
    logic        mdl_default_seed;

    task automatic mdl_seed(input logic [31:0] s);
        mdl_mt[0] = s;
        for (int i = 1; i < 624; i++)
            mdl_mt[i] = 32'd1812433253 * (mdl_mt[i-1] ^ (mdl_mt[i-1] >> 30)) + 32'(i);
        mdl_pos = 624;
        mdl_cnt = 0;
        mdl_default_seed = (s == 32'd5489);
    endtask

    function automatic logic [31:0] mdl_temper(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C_5680);
        y = y ^ ((y << 15) & 32'hEFC6_0000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    task automatic mdl_next(output logic [31:0] w);
        logic [31:0] y;
        if (mdl_pos == 624) begin
            for (int k = 0; k < 624; k++) begin
                y = (mdl_mt[k] & 32'h8000_0000) | (mdl_mt[(k+1) % 624] & 32'h7FFF_FFFF);
                mdl_mt[k] = mdl_mt[(k+397) % 624] ^ (y >> 1) ^ ((y & 32'd1) != 0 ? 32'h9908_B0DF : 32'd0);
            end
            mdl_pos = 0;
        end
        w = mdl_mt[mdl_pos];
`ifdef MT_TEMPER_EN
        w = mdl_temper(w);
`endif
        mdl_pos++;
        mdl_cnt++;
    endtask

    // ---------------- state RAM ----------------
    logic [31:0] ram [624];
    logic        seed_go;

    always @(posedge clk) begin
        if (seed_go) begin
            for (int i = 0; i < 624; i++) ram[i] <= mdl_mt[i];
        end else if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
        rd_data <= ram[rd_addr];
    end

    int collide = 0;
    always @(negedge clk) begin
        if (wr_en && (wr_addr == rd_addr)) collide++;
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] last_word;

    task automatic seed_both(input logic [31:0] s);
        mdl_seed(s);
        seed_go = 1'b1;
        @(negedge clk);
        seed_go = 1'b0;
        @(negedge clk);
    endtask

    // Collect n words with rand_ready high; returns one cycle after the
    // last transfer so the caller may change inputs safely.
    task automatic run_words(input int n, input int exp_first, input string tag);
        int cyc  = 0;
        int last = -1;
        int got  = 0;
        logic [31:0] exp_w;
        rand_ready = 1'b1;
        while (got < n && cyc < n * 6 + 30) begin
            @(negedge clk);
            cyc++;
            if (rand_valid) begin
                mdl_next(exp_w);
                check({tag, "_word"}, rand_out, exp_w);
`ifdef MT_TEMPER_EN
                if (mdl_default_seed && mdl_cnt == 1)     check("known_word1", rand_out, 32'hD091_BB5C);
                if (mdl_default_seed && mdl_cnt == 2)     check("known_word2", rand_out, 32'h22AE_9EF6);
                if (mdl_default_seed && mdl_cnt == 10000) check("known_word10000", rand_out, 32'd4123659995);
`endif
                if (got == 0 && exp_first >= 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_first));
                if (got > 0 && got < 8) check({tag, "_spacing"}, 32'(cyc - last), 32'd4);
                last_word = rand_out;
                last = cyc;
                got++;
            end
        end
        if (got < n) check({tag, "_timeout"}, 32'(got), 32'(n));
        @(negedge clk);
    endtask

    // Wait (bounded) for rand_valid with rand_ready low; returns 1 on success.
    task automatic wait_valid(input string tag, output bit ok);
        int cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rand_valid) ok = 1'b1;
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] exp_w;
        logic [31:0] held;
        int          wr_seen;
        bit          ok;

        rst           = 1'b1;
        current_state = 2'b00;
        rand_ready    = 1'b0;
        seed_go       = 1'b0;
        last_word     = '0;
        repeat (3) @(negedge clk);

        check("rst_rd_addr",    32'(rd_addr),    32'd0);
        check("rst_wr_addr",    32'(wr_addr),    32'd0);
        check("rst_wr_data",    wr_data,         32'd0);
        check("rst_wr_en",      32'(wr_en),      32'd0);
        check("rst_rand_out",   rand_out,        32'd0);
        check("rst_rand_valid", 32'(rand_valid), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Default seed, first words, latency and beat spacing.
        current_state = 2'b01;
        seed_both(32'd5489);
        current_state = 2'b10;
        run_words(3, 6, "first");

        // Backpressure on word 4.
        rand_ready = 1'b0;
        wait_valid("bp", ok);
        if (ok) begin
            mdl_next(exp_w);
            check("bp_word", rand_out, exp_w);
            held    = rand_out;
            wr_seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check("bp_hold_out", rand_out, held);
                check("bp_hold_valid", 32'(rand_valid), 32'd1);
                if (wr_en) wr_seen++;
            end
            check("bp_no_write", 32'(wr_seen), 32'd0);
            rand_ready = 1'b1;
            @(negedge clk);
            check("bp_valid_drop", 32'(rand_valid), 32'd0);
        end

        // Words 5..99, then abandon word 100 while it sits in OUT.
        run_words(95, -1, "seq_a");
        rand_ready = 1'b0;
        wait_valid("drop", ok);
        if (ok) begin
            mdl_next(exp_w);
            check("drop_word100", rand_out, exp_w);
            current_state = 2'b00;
            @(negedge clk);
            check("drop_valid", 32'(rand_valid), 32'd0);
            check("drop_busy",  32'(busy),       32'd0);
            repeat (3) @(negedge clk);
            current_state = 2'b10;
        end

        // Resume with word 101 and run through word 10000 (several wraps).
        run_words(10000 - mdl_cnt, 6, "seq_b");

        // Seeding mode mid-run: idx clears, rand_out kept as the new seed.
        current_state = 2'b01;
        @(negedge clk);
        check("seed_valid",   32'(rand_valid), 32'd0);
        check("seed_busy",    32'(busy),       32'd0);
        check("seed_rand_kept", rand_out, last_word);
        seed_both(last_word);
        current_state = 2'b10;
        run_words(700 + $urandom_range(0, 60), 6, "reseed");

        check("wr_rd_collide", 32'(collide), 32'd0);

        // Reset while in CALC.
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (wr_en) ok = 1'b1;
        end
        check("calc_found", 32'(ok), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstc_wr_en",      32'(wr_en),      32'd0);
        check("rstc_rd_addr",    32'(rd_addr),    32'd0);
        check("rstc_wr_addr",    32'(wr_addr),    32'd0);
        check("rstc_wr_data",    wr_data,         32'd0);
        check("rstc_rand_out",   rand_out,        32'd0);
        check("rstc_rand_valid", 32'(rand_valid), 32'd0);
        check("rstc_busy",       32'(busy),       32'd0);
        rst = 1'b0;
        current_state = 2'b00;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
